// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the 16x32 register memory (two read ports, one
// write port) between requester 0 (fixed priority) and requester 1, with a
// starvation limit that forces a requester-1 grant after MAX_BURST
// consecutive contested requester-0 grants.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/ready      per-requester handshake (ready is combinational)
//   reqN_we, reqN_re_a/b  write / read-port enables of the transaction
//   reqN_dir_a/b/wr       read/write addresses, reqN_di write data
//   rf_dir_a/b/wr, rf_di  registered address/data to the memory
//   rf_re_a_n/b_n, rf_we_n registered active-low memory enables
//   rf_data_a/b           read data from the memory
//   rsp_valid, rsp_id     response flag and issuing requester
//   rsp_data_a/b          read data passed straight through from the memory
module regfile_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned AW = 4,
    localparam int unsigned DW = 32,
    localparam int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic          req0_re_a,
    input  logic          req0_re_b,
    input  logic [AW-1:0] req0_dir_a,
    input  logic [AW-1:0] req0_dir_b,
    input  logic [AW-1:0] req0_dir_wr,
    input  logic [DW-1:0] req0_di,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic          req1_re_a,
    input  logic          req1_re_b,
    input  logic [AW-1:0] req1_dir_a,
    input  logic [AW-1:0] req1_dir_b,
    input  logic [AW-1:0] req1_dir_wr,
    input  logic [DW-1:0] req1_di,

    output logic [AW-1:0] rf_dir_a,
    output logic [AW-1:0] rf_dir_b,
    output logic [AW-1:0] rf_dir_wr,
    output logic [DW-1:0] rf_di,
    output logic          rf_re_a_n,
    output logic          rf_re_b_n,
    output logic          rf_we_n,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b,

    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data_a,
    output logic [DW-1:0] rsp_data_b
);

    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

    logic [CW-1:0] starve_cnt;
    logic          acc0;
    logic          acc1;
    logic          acc_any;
    logic          sel_we;
    logic          sel_re_a;
    logic          sel_re_b;
    logic [AW-1:0] sel_dir_a;
    logic [AW-1:0] sel_dir_b;
    logic [AW-1:0] sel_dir_wr;
    logic [DW-1:0] sel_di;
    logic          rd_flag1;
    logic          rd_id1;

    // Grant decision and selection of the accepted requester's fields
    always_comb begin
        req0_ready = rst_n & (~req1_valid | (starve_cnt < BURST_LIM));
        req1_ready = rst_n & (~req0_valid | (starve_cnt == BURST_LIM));
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready & ~acc0;
        acc_any    = acc0 | acc1;
        sel_we     = acc1 ? req1_we     : req0_we;
        sel_re_a   = acc1 ? req1_re_a   : req0_re_a;
        sel_re_b   = acc1 ? req1_re_b   : req0_re_b;
        sel_dir_a  = acc1 ? req1_dir_a  : req0_dir_a;
        sel_dir_b  = acc1 ? req1_dir_b  : req0_dir_b;
        sel_dir_wr = acc1 ? req1_dir_wr : req0_dir_wr;
        sel_di     = acc1 ? req1_di     : req0_di;
    end

    // Starvation counter, issue register and two-stage response pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rf_dir_a   <= '0;
            rf_dir_b   <= '0;
            rf_dir_wr  <= '0;
            rf_di      <= '0;
            rf_re_a_n  <= 1'b1;
            rf_re_b_n  <= 1'b1;
            rf_we_n    <= 1'b1;
            rd_flag1   <= 1'b0;
            rd_id1     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            // Only contested req0 grants count; req1 service or idle req1 clears
            if (acc1 || !req1_valid) begin
                starve_cnt <= '0;
            end else if (acc0 && starve_cnt < BURST_LIM) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            // Addresses/data hold when idle; enables always drop back to inactive
            if (acc_any) begin
                rf_dir_a  <= sel_dir_a;
                rf_dir_b  <= sel_dir_b;
                rf_dir_wr <= sel_dir_wr;
                rf_di     <= sel_di;
                rf_re_a_n <= ~sel_re_a;
                rf_re_b_n <= ~sel_re_b;
                rf_we_n   <= ~sel_we;
                rd_id1    <= acc1;
            end else begin
                rf_re_a_n <= 1'b1;
                rf_re_b_n <= 1'b1;
                rf_we_n   <= 1'b1;
            end

            rd_flag1  <= acc_any & (sel_re_a | sel_re_b);
            rsp_valid <= rd_flag1;
            rsp_id    <= rd_id1;
        end
    end

    // Memory read data is already registered by the memory; pass it through
    assign rsp_data_a = rf_data_a;
    assign rsp_data_b = rf_data_b;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a behavioural register memory sits on the rf_*
// side, and a reference model (register array plus grant counter) predicts
// readiness, issued enables and tagged responses for directed and random traffic.
module tb_regfile_arbiter;

    localparam int unsigned MB = 4;
    localparam logic [31:0] DIS = 32'h0000FFFF;

    typedef struct packed {
        logic        we;
        logic        re_a;
        logic        re_b;
        logic [3:0]  dir_a;
        logic [3:0]  dir_b;
        logic [3:0]  dir_wr;
        logic [31:0] di;
    } txn_t;

    typedef struct packed {
        logic        valid;
        logic        id;
        logic [31:0] da;
        logic [31:0] db;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req0_we, req0_re_a, req0_re_b;
    logic [3:0]  req0_dir_a, req0_dir_b, req0_dir_wr;
    logic [31:0] req0_di;
    logic        req1_valid, req1_ready, req1_we, req1_re_a, req1_re_b;
    logic [3:0]  req1_dir_a, req1_dir_b, req1_dir_wr;
    logic [31:0] req1_di;
    logic [3:0]  rf_dir_a, rf_dir_b, rf_dir_wr;
    logic [31:0] rf_di;
    logic        rf_re_a_n, rf_re_b_n, rf_we_n;
    logic [31:0] rf_data_a, rf_data_b;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_data_a, rsp_data_b;

    regfile_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_re_a(req0_re_a), .req0_re_b(req0_re_b), .req0_dir_a(req0_dir_a),
        .req0_dir_b(req0_dir_b), .req0_dir_wr(req0_dir_wr), .req0_di(req0_di),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_re_a(req1_re_a), .req1_re_b(req1_re_b), .req1_dir_a(req1_dir_a),
        .req1_dir_b(req1_dir_b), .req1_dir_wr(req1_dir_wr), .req1_di(req1_di),
        .rf_dir_a(rf_dir_a), .rf_dir_b(rf_dir_b), .rf_dir_wr(rf_dir_wr),
        .rf_di(rf_di), .rf_re_a_n(rf_re_a_n), .rf_re_b_n(rf_re_b_n),
        .rf_we_n(rf_we_n), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b)
    );

    // Register memory: writes land at negedge, reads sampled at posedge
    logic [31:0] mem [16] = '{default: 32'h0};
    logic [31:0] mem_qa = 32'h0;
    logic [31:0] mem_qb = 32'h0;
    always @(negedge clk) if (!rf_we_n) mem[rf_dir_wr] <= rf_di;
    always @(posedge clk) begin
        mem_qa <= rf_re_a_n ? DIS : mem[rf_dir_a];
        mem_qb <= rf_re_b_n ? DIS : mem[rf_dir_b];
    end
    assign rf_data_a = mem_qa;
    assign rf_data_b = mem_qb;

    // Reference model state
    logic [31:0] ref_regs [16] = '{default: 32'h0};
    rsp_t exp_p0 = '0;
    rsp_t exp_p1 = '0;
    int   consec0 = 0;
    int   checks = 0;
    int   failures = 0;

    txn_t t0, t1;
    logic v0, v1;
    int   g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic ra, input logic rb,
                                input logic [3:0] da, input logic [3:0] db,
                                input logic [3:0] dw, input logic [31:0] di);
        txn_t r;
        r.we = we; r.re_a = ra; r.re_b = rb;
        r.dir_a = da; r.dir_b = db; r.dir_wr = dw; r.di = di;
        return r;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 32'($urandom));
    endfunction

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs
    task automatic step(input logic rn, output int grant);
        logic er0, er1, a0, a1;
        txn_t tt;
        rsp_t nr;
        logic ewe, era, erb;
        @(negedge clk);
        rst_n = rn;
        req0_valid = v0; req0_we = t0.we; req0_re_a = t0.re_a; req0_re_b = t0.re_b;
        req0_dir_a = t0.dir_a; req0_dir_b = t0.dir_b; req0_dir_wr = t0.dir_wr; req0_di = t0.di;
        req1_valid = v1; req1_we = t1.we; req1_re_a = t1.re_a; req1_re_b = t1.re_b;
        req1_dir_a = t1.dir_a; req1_dir_b = t1.dir_b; req1_dir_wr = t1.dir_wr; req1_di = t1.di;
        #1;
        er0 = rn && (!v1 || consec0 < int'(MB));
        er1 = rn && (!v0 || consec0 >= int'(MB));
        chk("req0_ready", 32'(req0_ready), 32'(er0));
        chk("req1_ready", 32'(req1_ready), 32'(er1));
        a0 = v0 && er0;
        a1 = v1 && er1 && !a0;
        grant = a0 ? 0 : (a1 ? 1 : -1);
        @(posedge clk);
        if (!rn || a1 || !v1) consec0 = 0;
        else if (a0 && consec0 < int'(MB)) consec0++;
        nr = '0; ewe = 1'b1; era = 1'b1; erb = 1'b1;
        tt = a1 ? t1 : t0;
        if (a0 || a1) begin
            // Write first so a same-transaction read sees the new value
            if (tt.we) ref_regs[tt.dir_wr] = tt.di;
            nr.valid = tt.re_a | tt.re_b;
            nr.id = a1;
            nr.da = tt.re_a ? ref_regs[tt.dir_a] : DIS;
            nr.db = tt.re_b ? ref_regs[tt.dir_b] : DIS;
            ewe = !tt.we; era = !tt.re_a; erb = !tt.re_b;
        end
        if (!rn) begin
            exp_p1 = '0; exp_p0 = '0;
        end else begin
            exp_p1 = exp_p0; exp_p0 = nr;
        end
        #1;
        chk("rf_we_n", 32'(rf_we_n), 32'(ewe));
        chk("rf_re_a_n", 32'(rf_re_a_n), 32'(era));
        chk("rf_re_b_n", 32'(rf_re_b_n), 32'(erb));
        if ((a0 || a1) && tt.we) begin
            chk("rf_dir_wr", 32'(rf_dir_wr), 32'(tt.dir_wr));
            chk("rf_di", rf_di, tt.di);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_p1.valid));
        if (exp_p1.valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(exp_p1.id));
            chk("rsp_data_a", rsp_data_a, exp_p1.da);
            chk("rsp_data_b", rsp_data_b, exp_p1.db);
        end
    endtask

    initial begin
        // Reset held with both requesters valid
        v0 = 1'b1; v1 = 1'b1;
        t0 = mk(1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 32'hAAAA5555);
        t1 = mk(1'b1, 1'b1, 1'b1, 4'd4, 4'd5, 4'd6, 32'h5555AAAA);
        for (int i = 0; i < 3; i++) step(1'b0, g);
        chk("reset_rf_di", rf_di, 32'h0);
        chk("reset_rf_dir_a", 32'(rf_dir_a), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);

        // Single write, then read back on A with preloaded r3 on B
        v1 = 1'b0;
        t0 = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 32'd8979);
        step(1'b1, g);
        chk("preload_grant", 32'(g), 32'(0));
        t0 = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF);
        step(1'b1, g);
        t0 = mk(1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 4'd0, 32'h0);
        step(1'b1, g);
        v0 = 1'b0;
        step(1'b1, g);
        chk("wr_rd_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rd_id", 32'(rsp_id), 32'h0);
        chk("wr_rd_data_a", rsp_data_a, 32'hDEADBEEF);
        chk("wr_rd_data_b", rsp_data_b, 32'd8979);

        // Same-transaction write+read from requester 1
        v1 = 1'b1;
        t1 = mk(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 4'd7, 32'h12345678);
        step(1'b1, g);
        v1 = 1'b0;
        step(1'b1, g);
        chk("raw_id", 32'(rsp_id), 32'h1);
        chk("raw_data_a", rsp_data_a, 32'h12345678);
        chk("raw_data_b_disabled", rsp_data_b, DIS);

        // Disabled port B, then a pure write produces no response
        v0 = 1'b1;
        t0 = mk(1'b0, 1'b1, 1'b0, 4'd5, 4'd9, 4'd0, 32'h0);
        step(1'b1, g);
        t0 = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 32'hCAFEF00D);
        step(1'b1, g);
        chk("dis_data_a", rsp_data_a, 32'hDEADBEEF);
        chk("dis_data_b", rsp_data_b, DIS);
        v0 = 1'b0;
        step(1'b1, g);
        chk("pure_write_no_rsp", 32'(rsp_valid), 32'h0);
        step(1'b1, g);

        // Continuous contention: grant pattern 0,0,0,0,1 repeating
        v0 = 1'b1; v1 = 1'b1;
        t0 = mk(1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 32'h0);
        t1 = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 4'd0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, g);
            chk("starve_grant", 32'(g), (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        v0 = 1'b0; v1 = 1'b0;
        step(1'b1, g);
        step(1'b1, g);

        // Reset sampled one edge after a read handshake flushes the response
        v0 = 1'b1;
        t0 = mk(1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 4'd0, 32'h0);
        step(1'b1, g);
        chk("flush_grant", 32'(g), 32'(0));
        v0 = 1'b0;
        step(1'b0, g);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'h0);
        step(1'b1, g);
        chk("flush_rsp_valid_after", 32'(rsp_valid), 32'h0);
        chk("flush_re_a_n", 32'(rf_re_a_n), 32'h1);

        // Random traffic with occasional resets
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!v0 || g == 0) begin
                v0 = ($urandom_range(0, 3) != 0);
                t0 = rnd_txn();
            end
            if (!v1 || g == 1) begin
                v1 = ($urandom_range(0, 3) != 0);
                t1 = rnd_txn();
            end
            step(($urandom_range(0, 59) != 0), g);
        end

        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
